// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, shift-fill selectors and FSM states.
// Optional multiplier datapath is enabled with SEQ_ALU_MUL_EN (see seq_alu.sv).
package seq_alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        CEQ  = 3'd2,
        CLT  = 3'd3,
        SHL  = 3'd4,
        SHR  = 3'd5,
        MUL  = 3'd6,
        PASS = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_FLAG = 2'd1,
        FILL_OVF  = 2'd2
    } fill_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoding 3 is reserved and behaves as zero fill.
    function automatic logic fill_bit(input logic [1:0] fill, input logic flag,
                                      input logic ovf);
        logic b;
        b = 1'b0;
        if (fill == FILL_FLAG) begin
            b = flag;
        end else if (fill == FILL_OVF) begin
            b = ovf;
        end
        return b;
    endfunction

endpackage

// File: rtl/alu_comb_n.sv
// Single-cycle arithmetic/compare/pass slice of the sequential ALU.
// Shift and multiply ops yield zero here; they are sequenced by seq_alu.
module alu_comb_n
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  seq_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flag_i,
    input  logic             ovf_i,
    output logic [WIDTH-1:0] res_o,
    output logic             flag_o,
    output logic             ovf_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        // The MSB of the (WIDTH+1)-bit difference is the unsigned borrow.
        sum    = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, ovf_i};
        diff   = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, ovf_i};
        res_o  = '0;
        flag_o = flag_i;
        ovf_o  = 1'b0;
        case (op_i)
            ADD: begin
                res_o = sum[WIDTH-1:0];
                ovf_o = sum[WIDTH];
            end
            SUB: begin
                res_o = diff[WIDTH-1:0];
                ovf_o = diff[WIDTH];
            end
            CEQ:     flag_o = (a_i == b_i);
            CLT:     flag_o = (a_i < b_i);
            PASS:    res_o  = b_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, bit-serial shifts and optional iterative
// multiply. Define SEQ_ALU_MUL_EN to build the shift-add multiplier.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [1:0]       FILL,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    input  logic             FLAG_IN,
    input  logic             OVERFLOW_IN,
    input  logic             ABORT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             FLAG_OUT,
    output logic             OVERFLOW_OUT
);

    localparam int SHAMT_W = $clog2(WIDTH) + 1;
    localparam logic [SHAMT_W-1:0] CntFull  = SHAMT_W'(WIDTH);
    localparam logic [WIDTH:0]     WidthExt = (WIDTH + 1)'(WIDTH);

    state_t               state_q, state_d;
    seq_op_t              op_q, op_d, op_in;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d, shamt;
    logic [WIDTH-1:0]     work_q, work_d;
    logic                 fillb_q, fillb_d, flag_q, flag_d, fill_in;
    logic [WIDTH-1:0]     out_q, out_d, out_hi_q, out_hi_d;
    logic                 flag_out_q, flag_out_d, ovf_out_q, ovf_out_d;
    logic [WIDTH-1:0]     step_lo, step_hi;
    logic                 step_bit;
    logic [WIDTH-1:0]     comb_res;
    logic                 comb_flag, comb_ovf;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0]     mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH:0]       psum;
`endif

    assign op_in   = seq_op_t'(OP);
    assign fill_in = fill_bit(FILL, FLAG_IN, OVERFLOW_IN);
    assign shamt   = ({1'b0, INPUTB} >= WidthExt) ? CntFull : INPUTB[SHAMT_W-1:0];

    alu_comb_n #(
        .WIDTH(WIDTH)
    ) u_comb (
        .op_i  (op_in),
        .a_i   (INPUTA),
        .b_i   (INPUTB),
        .flag_i(FLAG_IN),
        .ovf_i (OVERFLOW_IN),
        .res_o (comb_res),
        .flag_o(comb_flag),
        .ovf_o (comb_ovf)
    );

    // One RUN step: shift by a bit, or one shift-add multiplier iteration.
    always_comb begin
        step_lo  = work_q;
        step_hi  = '0;
        step_bit = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        psum     = '0;
`endif
        case (op_q)
            SHL: begin
                step_lo  = {work_q[WIDTH-2:0], fillb_q};
                step_bit = work_q[WIDTH-1];
            end
            SHR: begin
                step_lo  = {fillb_q, work_q[WIDTH-1:1]};
                step_bit = work_q[0];
            end
`ifdef SEQ_ALU_MUL_EN
            MUL: begin
                psum    = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
                step_hi = psum[WIDTH:1];
                step_lo = {psum[0], work_q[WIDTH-1:1]};
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        fillb_d    = fillb_q;
        flag_d     = flag_q;
        out_d      = out_q;
        out_hi_d   = out_hi_q;
        flag_out_d = flag_out_q;
        ovf_out_d  = ovf_out_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d    = mcand_q;
        acc_d      = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    op_d    = op_in;
                    flag_d  = FLAG_IN;
                    fillb_d = fill_in;
                    work_d  = INPUTA;
                    case (op_in)
                        SHL, SHR: begin
                            cnt_d = shamt;
                            if (shamt == '0) begin
                                state_d    = DONE;
                                out_d      = INPUTA;
                                out_hi_d   = '0;
                                flag_out_d = FLAG_IN;
                                ovf_out_d  = 1'b0;
                            end else begin
                                state_d = RUN;
                            end
                        end
                        MUL: begin
`ifdef SEQ_ALU_MUL_EN
                            work_d  = INPUTB;
                            mcand_d = INPUTA;
                            acc_d   = '0;
                            cnt_d   = CntFull;
                            state_d = RUN;
`else
                            // No multiplier: report the op as illegal.
                            state_d    = DONE;
                            out_d      = '0;
                            out_hi_d   = '0;
                            flag_out_d = FLAG_IN;
                            ovf_out_d  = 1'b1;
`endif
                        end
                        default: begin
                            state_d    = DONE;
                            out_d      = comb_res;
                            out_hi_d   = '0;
                            flag_out_d = comb_flag;
                            ovf_out_d  = comb_ovf;
                        end
                    endcase
                end
            end
            RUN: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else begin
                    work_d = step_lo;
`ifdef SEQ_ALU_MUL_EN
                    acc_d  = step_hi;
`endif
                    cnt_d  = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d    = DONE;
                        out_d      = step_lo;
                        out_hi_d   = step_hi;
                        flag_out_d = flag_q;
                        ovf_out_d  = (op_q == MUL) ? |step_hi : step_bit;
                    end
                end
            end
            DONE: begin
                if (ABORT || OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            op_q       <= ADD;
            cnt_q      <= '0;
            work_q     <= '0;
            fillb_q    <= 1'b0;
            flag_q     <= 1'b0;
            out_q      <= '0;
            out_hi_q   <= '0;
            flag_out_q <= 1'b0;
            ovf_out_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q    <= '0;
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            fillb_q    <= fillb_d;
            flag_q     <= flag_d;
            out_q      <= out_d;
            out_hi_q   <= out_hi_d;
            flag_out_q <= flag_out_d;
            ovf_out_q  <= ovf_out_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign IN_READY     = (state_q == IDLE);
    assign OUT_VALID    = (state_q == DONE);
    assign OUT          = out_q;
    assign OUT_HI       = out_hi_q;
    assign FLAG_OUT     = flag_out_q;
    assign OVERFLOW_OUT = ovf_out_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8; MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;

    logic         CLK;
    logic         RESET;
    logic         IN_VALID;
    logic         IN_READY;
    logic [2:0]   OP;
    logic [1:0]   FILL;
    logic [W-1:0] INPUTA;
    logic [W-1:0] INPUTB;
    logic         FLAG_IN;
    logic         OVERFLOW_IN;
    logic         ABORT;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] OUT;
    logic [W-1:0] OUT_HI;
    logic         FLAG_OUT;
    logic         OVERFLOW_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    seq_alu #(
        .WIDTH(W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .OP          (OP),
        .FILL        (FILL),
        .INPUTA      (INPUTA),
        .INPUTB      (INPUTB),
        .FLAG_IN     (FLAG_IN),
        .OVERFLOW_IN (OVERFLOW_IN),
        .ABORT       (ABORT),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT         (OUT),
        .OUT_HI      (OUT_HI),
        .FLAG_OUT    (FLAG_OUT),
        .OVERFLOW_OUT(OVERFLOW_OUT)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op for a single accept edge, then scramble the inputs.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] fill, input logic flag, input logic ovf);
        OP          = op;
        INPUTA      = a;
        INPUTB      = b;
        FILL        = fill;
        FLAG_IN     = flag;
        OVERFLOW_IN = ovf;
        IN_VALID    = 1'b1;
        tick();
        IN_VALID    = 1'b0;
        OP          = ~op;
        INPUTA      = ~a;
        INPUTB      = ~b;
        FILL        = ~fill;
        FLAG_IN     = ~flag;
        OVERFLOW_IN = ~ovf;
    endtask

    task automatic wait_done(input string tag, input int r);
        for (int i = 0; i < r; i++) begin
            chk({tag, "_busy"}, {30'd0, OUT_VALID, IN_READY}, 32'd0);
            tick();
        end
        chk({tag, "_valid"}, OUT_VALID, 1);
    endtask

    task automatic chk_res(input string tag, input logic [7:0] o, input logic [7:0] hi,
                           input logic f, input logic v);
        chk({tag, "_out"}, OUT, o);
        chk({tag, "_hi"}, OUT_HI, hi);
        chk({tag, "_flag"}, FLAG_OUT, f);
        chk({tag, "_ovf"}, OVERFLOW_OUT, v);
    endtask

    task automatic handoff(input string tag);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk({tag, "_ho_valid"}, OUT_VALID, 0);
        chk({tag, "_ho_ready"}, IN_READY, 1);
    endtask

    initial begin
        RESET       = 1'b1;
        IN_VALID    = 1'b0;
        OP          = 3'd0;
        FILL        = 2'd0;
        INPUTA      = '0;
        INPUTB      = '0;
        FLAG_IN     = 1'b0;
        OVERFLOW_IN = 1'b0;
        ABORT       = 1'b0;
        OUT_READY   = 1'b0;
        tick();
        chk("rst_ready", IN_READY, 1);
        chk("rst_valid", OUT_VALID, 0);
        chk_res("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        RESET = 1'b0;
        tick();

        // ABORT in IDLE must not block the accept.
        ABORT = 1'b1;
        issue(ADD, 8'hF0, 8'h20, 2'd0, 1'b0, 1'b1);
        ABORT = 1'b0;
        wait_done("add", 0);
        chk("add_notready", IN_READY, 0);
        chk_res("add", 8'h11, 8'h00, 1'b0, 1'b1);
        handoff("add");

        // SUB, then ABORT out of DONE keeps outputs.
        issue(SUB, 8'h05, 8'h07, 2'd0, 1'b1, 1'b0);
        wait_done("sub", 0);
        chk_res("sub", 8'hFE, 8'h00, 1'b1, 1'b1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("sub_abort_valid", OUT_VALID, 0);
        chk("sub_abort_ready", IN_READY, 1);
        chk("sub_abort_hold", OUT, 8'hFE);

        issue(SHL, 8'h81, 8'h03, 2'd1, 1'b1, 1'b0);
        wait_done("shl3", 3);
        chk_res("shl3", 8'h0F, 8'h00, 1'b1, 1'b0);
        handoff("shl3");
        chk("shl3_keep", OUT, 8'h0F);

        issue(SHR, 8'hA5, 8'h09, 2'd0, 1'b0, 1'b0);
        wait_done("shr_sat", 8);
        chk_res("shr_sat", 8'h00, 8'h00, 1'b0, 1'b1);
        handoff("shr_sat");

        issue(SHL, 8'h3C, 8'h00, 2'd1, 1'b1, 1'b1);
        wait_done("shl0", 0);
        chk_res("shl0", 8'h3C, 8'h00, 1'b1, 1'b0);
        handoff("shl0");

        issue(SHR, 8'h01, 8'h02, 2'd2, 1'b0, 1'b1);
        wait_done("shr_ovf", 2);
        chk_res("shr_ovf", 8'hC0, 8'h00, 1'b0, 1'b0);
        handoff("shr_ovf");

        // ABORT during RUN: back to IDLE, no result, outputs untouched.
        issue(SHL, 8'hFF, 8'h06, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_ready", IN_READY, 1);
        chk("abort_valid", OUT_VALID, 0);
        chk("abort_hold", OUT, 8'hC0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_quiet", OUT_VALID, 0);
        end

        issue(MUL, 8'hFF, 8'hFF, 2'd0, 1'b0, 1'b0);
`ifdef SEQ_ALU_MUL_EN
        wait_done("mul", 8);
        chk_res("mul", 8'h01, 8'hFE, 1'b0, 1'b1);
`else
        wait_done("mul", 0);
        chk_res("mul", 8'h00, 8'h00, 1'b0, 1'b1);
`endif
        handoff("mul");

        // Backpressure: result held, then no accept in DONE.
        issue(CEQ, 8'h3C, 8'h3C, 2'd0, 1'b0, 1'b1);
        wait_done("ceq", 0);
        chk_res("ceq", 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ceq_hold_valid", OUT_VALID, 1);
            chk("ceq_hold_flag", FLAG_OUT, 1);
        end
        OP          = PASS;
        INPUTA      = 8'h00;
        INPUTB      = 8'h77;
        FILL        = 2'd0;
        FLAG_IN     = 1'b0;
        OVERFLOW_IN = 1'b1;
        IN_VALID    = 1'b1;
        OUT_READY   = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("ceq_ho_valid", OUT_VALID, 0);
        chk("ceq_ho_ready", IN_READY, 1);
        chk("ceq_ho_flag", FLAG_OUT, 1);
        tick();
        IN_VALID = 1'b0;
        chk("pass_valid", OUT_VALID, 1);
        chk_res("pass", 8'h77, 8'h00, 1'b0, 1'b0);
        handoff("pass");

        issue(CLT, 8'h04, 8'h05, 2'd0, 1'b0, 1'b1);
        wait_done("clt", 0);
        chk_res("clt", 8'h00, 8'h00, 1'b1, 1'b0);
        handoff("clt");

        issue(CLT, 8'h05, 8'h04, 2'd0, 1'b1, 1'b0);
        wait_done("clt_n", 0);
        chk_res("clt_n", 8'h00, 8'h00, 1'b0, 1'b0);
        handoff("clt_n");

        // Asynchronous reset in the middle of a shift.
        issue(SHR, 8'hFF, 8'h05, 2'd1, 1'b1, 1'b1);
        tick();
        RESET = 1'b1;
        #1;
        chk("mid_rst_ready", IN_READY, 1);
        chk("mid_rst_valid", OUT_VALID, 0);
        chk_res("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_quiet", OUT_VALID, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational datapath ALU. Accepts one operation per valid/ready handshake and returns a registered result with OUT_VALID.
- Adds WIDTH generalisation, variable-amount shifts (one bit per cycle, selectable fill), an iterative unsigned multiply with a high result word, output backpressure and an abort.
- Sits between the register file and the writeback mux; the controller stalls on IN_READY.

Parameters:
- WIDTH, 8, datapath width in bits; legal values are 2 or more.
- SHAMT_W, $clog2(WIDTH)+1, derived localparam; width of the shift-amount and run counter.

Ports:
- CLK  input  1  clock; all state on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operation request.
- IN_READY  output  1  block can accept; high only in IDLE.
- OP  input  3  opcode: ADD=0, SUB=1, CEQ=2, CLT=3, SHL=4, SHR=5, MUL=6, PASS=7.
- FILL  input  2  shift fill: 0=zero, 1=FLAG_IN, 2=OVERFLOW_IN, 3=zero.
- INPUTA  input  WIDTH  operand A.
- INPUTB  input  WIDTH  operand B; shift amount for SHL/SHR.
- FLAG_IN  input  1  current flag.
- OVERFLOW_IN  input  1  carry/borrow in.
- ABORT  input  1  synchronous cancel of the operation in progress.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer takes the result.
- OUT  output  WIDTH  result, low word.
- OUT_HI  output  WIDTH  MUL high word; 0 for all other ops.
- FLAG_OUT  output  1  flag result.
- OVERFLOW_OUT  output  1  carry/borrow/last shifted-out bit.

Behaviour:
- Reset (asynchronous): state=IDLE; IN_READY=1; OUT_VALID=0; OUT, OUT_HI, FLAG_OUT, OVERFLOW_OUT all 0. Reset mid-operation discards the operation with no OUT_VALID.
- Accept: IN_VALID&IN_READY at edge k. All inputs are latched at k; later input changes are ignored.
- FSM states and transitions:
  - IDLE: accept -> RUN, or -> DONE when the run count is 0.
  - RUN: one step per cycle; count decrements; goes to DONE when the count is 0.
  - DONE: OUT_VALID=1; leaves to IDLE on OUT_READY.
- Latency: OUT_VALID rises at edge k+1+R.
  - R=0 for ADD/SUB/CEQ/CLT/PASS.
  - R=n for shifts.
  - R=WIDTH for MUL.
- No input accept in DONE, even when OUT_READY is high in the same cycle. The next accept is possible one cycle after the DONE->IDLE edge.
- Output hold: outputs stay stable while OUT_VALID&!OUT_READY. Outputs keep their last value after the handoff; they change only when a new result lands in DONE.
- ADD: {OVERFLOW_OUT,OUT} = A+B+OVERFLOW_IN, computed at WIDTH+1 bits.
- SUB: OUT = A-B-OVERFLOW_IN mod 2^WIDTH. OVERFLOW_OUT = borrow, i.e. 1 when A < B+OVERFLOW_IN, unsigned.
- CEQ: FLAG_OUT = (A==B). CLT: FLAG_OUT = (A<B), unsigned. For both, OUT=0 and OVERFLOW_OUT=0.
- PASS: OUT=B, OVERFLOW_OUT=0.
- FLAG_OUT = latched FLAG_IN for every op except CEQ/CLT.
- Shifts:
  - n = min(B, WIDTH).
  - Each RUN cycle shifts by one bit and inserts the fill bit selected by FILL, sampled at accept.
  - OVERFLOW_OUT = last bit shifted out.
  - n=0: OUT=A, OVERFLOW_OUT=0.
  - n=WIDTH: OUT is all fill bits; OVERFLOW_OUT is A[0] for SHL and A[WIDTH-1] for SHR.
- MUL: unsigned shift-add, one multiplier bit per RUN cycle. {OUT_HI,OUT} = A*B; OVERFLOW_OUT = |OUT_HI.
- ABORT: honoured in RUN or DONE -> IDLE next edge. OUT_VALID drops and outputs keep their previous values. ABORT in IDLE has no effect; it does not block an accept in the same cycle.
- RESET has priority over ABORT, and ABORT over RUN progress.

Optional Feature:
- Macro SEQ_ALU_MUL_EN.
- Defined: MUL as above.
- Undefined: multiplier datapath is absent. MUL completes with R=0: OUT=0, OUT_HI=0, OVERFLOW_OUT=1 (illegal-op marker), FLAG_OUT=FLAG_IN.

Decomposition:
- Package definitions (extend): seq_op_t enum (ADD..PASS) and fill_t enum (FILL_ZERO, FILL_FLAG, FILL_OVF); state_t enum {IDLE, RUN, DONE}.
- One sub-module, alu_comb_n, parametrised by WIDTH: combinational ADD/SUB/CEQ/CLT/PASS evaluated at accept.
- Shift/MUL sequencing and the FSM stay in seq_alu.

Test Plan (WIDTH=8):
- ADD A=F0 B=20 OVERFLOW_IN=1 -> OUT=11, OVERFLOW_OUT=1, OUT_VALID at k+1. SUB A=05 B=07 OVERFLOW_IN=0 -> OUT=FE, OVERFLOW_OUT=1.
- SHL A=81 B=3 FILL=1 FLAG_IN=1 -> OUT=0F, OVERFLOW_OUT=0, OUT_VALID at k+4; IN_READY=0 during k+1..k+4.
- SHR A=A5 B=09 FILL=0 -> saturates to n=8: OUT=00, OVERFLOW_OUT=1, OUT_VALID at k+9. SHL B=0 -> OUT=A, valid at k+1.
- MUL A=FF B=FF -> OUT=01, OUT_HI=FE, OVERFLOW_OUT=1 at k+9. Without SEQ_ALU_MUL_EN -> OUT=00, OUT_HI=00, OVERFLOW_OUT=1 at k+1.
- CEQ A=3C B=3C with OUT_READY=0 for 5 cycles -> FLAG_OUT=1 and OUT_VALID held stable; handoff on OUT_READY; next accept one cycle later.
- ABORT at k+3 of a MUL -> IDLE at k+4 with no OUT_VALID. RESET at k+2 of a shift -> all outputs 0 immediately, IN_READY=1.
